// File: rtl/stopwatch_pkg.sv
// Shared types and digit constants for the mm:ss lap stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StPause} sw_state_e;

  localparam int unsigned SuW   = 4;
  localparam int unsigned StW   = 3;
  localparam int unsigned MuW   = 4;
  localparam int unsigned MtW   = 4;
  localparam int unsigned SuMax = 9;
  localparam int unsigned StMax = 5;
  localparam int unsigned MuMax = 9;

endpackage

// File: rtl/bcd_digit.sv
// One wrapping counter digit; carry fires in the cycle an increment wraps it from MAX to 0.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = SuMax,
  parameter int unsigned W   = SuW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         carry
);

  logic [W-1:0] value_q, value_d;
  logic         at_max;

  assign at_max = (value_q == W'(MAX));
  assign carry  = inc && at_max;
  assign value  = value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = at_max ? '0 : value_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/stopwatch_lap.sv
// mm:ss stopwatch with prescaler, run/pause/clear control and lap freeze.
// Define STOPWATCH_SAT_EN to saturate at full count instead of wrapping to 00:00.
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned MT_MAX   = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  input  logic           lap,
  input  logic           clear,
  output logic [SuW-1:0] su,
  output logic [StW-1:0] st,
  output logic [MuW-1:0] mu,
  output logic [MtW-1:0] mt,
  output logic           running,
  output logic           lap_active,
  output logic           ovf
);

  localparam int unsigned    PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  TickLast = PW'(TICK_DIV - 1);
  localparam logic [MtW-1:0] MtMax    = MtW'(MT_MAX);

  sw_state_e      state_q;
  logic [PW-1:0]  presc_q;
  logic           running_q, lap_active_q, ovf_q;
  logic [SuW-1:0] lap_su_q, su_live;
  logic [StW-1:0] lap_st_q, st_live;
  logic [MuW-1:0] lap_mu_q, mu_live;
  logic [MtW-1:0] lap_mt_q, mt_live;
  logic           c_su, c_st, c_mu, c_mt;
  logic           tick, full, inc_su;
  logic           ev_start, ev_stop, ev_lap;

  // Only the highest-priority asserted input acts in a cycle.
  assign ev_stop  = stop && !clear;
  assign ev_start = start && !stop && !clear;
  assign ev_lap   = lap && !start && !stop && !clear;

  assign tick = (state_q == StRun) && (presc_q == TickLast) && !clear;
  assign full = (su_live == SuW'(SuMax)) && (st_live == StW'(StMax)) &&
                (mu_live == MuW'(MuMax)) && (mt_live == MtMax);

`ifdef STOPWATCH_SAT_EN
  assign inc_su = tick && !full;
`else
  assign inc_su = tick;
`endif

  bcd_digit #(.MAX(SuMax), .W(SuW)) u_su (
    .clk(clk), .rst(rst), .clr(clear), .inc(inc_su), .value(su_live), .carry(c_su)
  );
  bcd_digit #(.MAX(StMax), .W(StW)) u_st (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_su), .value(st_live), .carry(c_st)
  );
  bcd_digit #(.MAX(MuMax), .W(MuW)) u_mu (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_st), .value(mu_live), .carry(c_mu)
  );
  bcd_digit #(.MAX(MT_MAX), .W(MtW)) u_mt (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_mu), .value(mt_live), .carry(c_mt)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      ovf_q        <= 1'b0;
      lap_su_q     <= '0;
      lap_st_q     <= '0;
      lap_mu_q     <= '0;
      lap_mt_q     <= '0;
    end else begin
      if (state_q == StRun) begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
      end
      if (c_mt || (tick && full)) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (ev_start) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (ev_stop) begin
            state_q   <= StPause;
            running_q <= 1'b0;
          end else if (ev_lap) begin
            lap_active_q <= !lap_active_q;
            // Freeze the pre-increment value seen this cycle.
            if (!lap_active_q) begin
              lap_su_q <= su_live;
              lap_st_q <= st_live;
              lap_mu_q <= mu_live;
              lap_mt_q <= mt_live;
            end
          end
        end
        StPause: begin
          if (ev_start) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end else if (ev_lap && lap_active_q) begin
            lap_active_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign su         = lap_active_q ? lap_su_q : su_live;
  assign st         = lap_active_q ? lap_st_q : st_live;
  assign mu         = lap_active_q ? lap_mu_q : mu_live;
  assign mt         = lap_active_q ? lap_mt_q : mt_live;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign ovf        = ovf_q;

endmodule
